// File: rtl/aes_pkg.sv
// AES shared package: GF(2^8) helpers and the InvMixColumns FSM state type.
// Used by both the encrypt and decrypt datapaths; no ports.
package aes_pkg;

    localparam logic [7:0] AES_RED_POLY = 8'h1B;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } imc_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_RED_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul11(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul13(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul14(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/inv_mix_columns_iter_if.sv
// InvMixColumns handshake bundle: input side and output side valid/ready.
// master = upstream/downstream driver, slave = the inv_mix_columns_iter block.
interface inv_mix_columns_iter_if;

    logic         in_valid;
    logic         in_ready;
    logic         bypass;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic         busy;

    modport master (
        output in_valid,
        output bypass,
        output state_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  state_out,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  bypass,
        input  state_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output state_out,
        output busy
    );

endinterface

// File: rtl/inv_mix_single_column.sv
// One InvMixColumns column: combinational 32b -> 32b over GF(2^8).
// Ports: col_in (a0 at [31:24]), col_out (r0 at [31:24]).
module inv_mix_single_column
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] r0, r1, r2, r3;

    assign a0 = col_in[31:24];
    assign a1 = col_in[23:16];
    assign a2 = col_in[15:8];
    assign a3 = col_in[7:0];

    assign r0 = gf_mul14(a0) ^ gf_mul11(a1)
              ^ gf_mul13(a2) ^ gf_mul9(a3);
    assign r1 = gf_mul9(a0)  ^ gf_mul14(a1)
              ^ gf_mul11(a2) ^ gf_mul13(a3);
    assign r2 = gf_mul13(a0) ^ gf_mul9(a1)
              ^ gf_mul14(a2) ^ gf_mul11(a3);
    assign r3 = gf_mul11(a0) ^ gf_mul13(a1)
              ^ gf_mul9(a2)  ^ gf_mul14(a3);

    assign col_out = {r0, r1, r2, r3};

endmodule

// File: rtl/inv_mix_columns_iter.sv
// InvMixColumns for AES decrypt, iterative (one column/cycle) by default.
// Define INV_MIX_COLUMNS_PARALLEL_EN for four column units (one BUSY cycle).
// Ports: clk, rst (async, active-low), bus (slave modport):
//   in_valid/in_ready/bypass/state_in, out_valid/out_ready/state_out, busy.
// Param HOLD_OUTPUT: 1 keeps state_out after the output handshake, 0 clears.
module inv_mix_columns_iter
    import aes_pkg::*;
#(
    parameter bit HOLD_OUTPUT = 1'b1
)(
    input  logic                      clk,
    input  logic                      rst,
    inv_mix_columns_iter_if.slave     bus
);

    imc_state_t   state_q, state_d;
    logic [127:0] work_q, work_d;
    logic [127:0] out_q, out_d;
    logic         vld_q, vld_d;

    // Work register after this cycle's column update(s).
    logic [127:0] mix_all;
    // This BUSY cycle writes the final column.
    logic         last;

`ifdef INV_MIX_COLUMNS_PARALLEL_EN

    for (genvar g = 0; g < 4; g++) begin : g_col
        inv_mix_single_column u_col (
            .col_in  (work_q[127-32*g -: 32]),
            .col_out (mix_all[127-32*g -: 32])
        );
    end

    assign last = 1'b1;

`else

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] col_sel;
    logic [31:0] col_new;

    always_comb begin
        col_sel = work_q[127:96];
        unique case (cnt_q)
            2'd0: col_sel = work_q[127:96];
            2'd1: col_sel = work_q[95:64];
            2'd2: col_sel = work_q[63:32];
            2'd3: col_sel = work_q[31:0];
            default: col_sel = work_q[127:96];
        endcase
    end

    inv_mix_single_column u_col (
        .col_in  (col_sel),
        .col_out (col_new)
    );

    always_comb begin
        mix_all = work_q;
        unique case (cnt_q)
            2'd0: mix_all[127:96] = col_new;
            2'd1: mix_all[95:64]  = col_new;
            2'd2: mix_all[63:32]  = col_new;
            2'd3: mix_all[31:0]   = col_new;
            default: mix_all = work_q;
        endcase
    end

    assign last = (cnt_q == 2'd3);

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == BUSY) begin
            cnt_d = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`endif

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        out_d   = out_q;
        vld_d   = vld_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    work_d = bus.state_in;
                    if (bus.bypass) begin
                        state_d = DONE;
                        out_d   = bus.state_in;
                        vld_d   = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                work_d = mix_all;
                if (last) begin
                    state_d = DONE;
                    out_d   = mix_all;
                    vld_d   = 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    vld_d   = 1'b0;
                    if (!HOLD_OUTPUT) begin
                        out_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            out_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
        end
    end

    // Held low while in reset so every output reads 0 during reset.
    assign bus.in_ready  = rst && (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = vld_q;
    assign bus.state_out = out_q;

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Testbench for inv_mix_columns_iter: directed FIPS vectors, bypass,
// backpressure, mid-operation reset and an encrypt/decrypt round trip.
module tb_inv_mix_columns_iter;

`ifdef INV_MIX_COLUMNS_PARALLEL_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 5;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    inv_mix_columns_iter_if bus ();

    inv_mix_columns_iter #(
        .HOLD_OUTPUT (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [127:0] sb[$];

    task automatic chk(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Monitor: every output handshake pops one expected state.
    always @(negedge clk) begin
        if (rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                fail_now("unexpected_output");
            end else begin
                chk("result", bus.state_out, sb.pop_front());
            end
        end
    end

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Encrypt-side MixColumns, used to build round-trip stimulus.
    function automatic logic [127:0] fwd_mix(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0] a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xt(a0) ^ (xt(a1) ^ a1) ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xt(a1) ^ (xt(a2) ^ a2) ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ (xt(a3) ^ a3);
            r[103-32*c -: 8] = (xt(a0) ^ a0) ^ a1 ^ a2 ^ xt(a3);
        end
        return r;
    endfunction

    // Issue one block; optionally measure accept -> out_valid latency.
    task automatic send(input logic [127:0] d,
                        input logic         byp,
                        input logic [127:0] exp,
                        input int           lat);
        int k;
        @(posedge clk) #1;
        bus.in_valid = 1'b1;
        bus.state_in = d;
        bus.bypass   = byp;
        k = 0;
        @(negedge clk);
        while (!bus.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!bus.in_ready) begin
            fail_now("accept_timeout");
        end
        sb.push_back(exp);
        @(posedge clk) #1;
        bus.in_valid = 1'b0;
        bus.bypass   = 1'b0;
        if (lat > 0) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!bus.out_valid && k < 20);
            chk("latency", 128'(k), 128'(lat));
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (!bus.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!bus.in_ready) begin
            fail_now("idle_timeout");
        end
    endtask

    localparam logic [127:0] V1  = {4{32'h8e4da1bc}};
    localparam logic [127:0] E1  = {4{32'hdb135345}};
    localparam logic [127:0] V2  = {32'h8e4da1bc, 32'h9fdc589d,
                                    32'hd5d5d7d6, 32'h01010101};
    localparam logic [127:0] E2  = {32'hdb135345, 32'hf20a225c,
                                    32'hd4d4d4d5, 32'h01010101};
    localparam logic [127:0] VB  = 128'h000102030405060708090a0b0c0d0e0f;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] d;
        bus.in_valid  = 1'b0;
        bus.bypass    = 1'b0;
        bus.state_in  = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_state_out", bus.state_out, '0);
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_in_ready", 128'(bus.in_ready), 128'(0));
        rst = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", 128'(bus.in_ready), 128'(1));

        // FIPS vector and mixed columns
        send(V1, 1'b0, E1, LAT);
        send(V2, 1'b0, E2, LAT);

        // Bypass
        send(VB, 1'b1, VB, 1);
        wait_idle();
        chk("hold_after_hs", bus.state_out, VB);
        chk("valid_low_after_hs", 128'(bus.out_valid), 128'(0));

        // Backpressure with ignored in_valid pulses
        bus.out_ready = 1'b0;
        send(V2, 1'b0, E2, LAT);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk) #1;
            bus.in_valid = i[0];
            bus.bypass   = 1'b1;
            bus.state_in = {4{32'hdeadbeef}} ^ 128'(i);
            @(negedge clk);
            chk("bp_out_valid", 128'(bus.out_valid), 128'(1));
            chk("bp_state_out", bus.state_out, E2);
            chk("bp_in_ready", 128'(bus.in_ready), 128'(0));
        end
        @(posedge clk) #1;
        bus.in_valid  = 1'b0;
        bus.bypass    = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle_busy", 128'(bus.busy), 128'(0));
        chk("bp_idle_in_ready", 128'(bus.in_ready), 128'(1));
        chk("bp_hold", bus.state_out, E2);

        // Reset in the middle of BUSY
        send(V1, 1'b0, E1, 0);
`ifndef INV_MIX_COLUMNS_PARALLEL_EN
        @(posedge clk) #1;
`endif
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("mid_rst_state_out", bus.state_out, '0);
        chk("mid_rst_busy", 128'(bus.busy), 128'(0));
        chk("mid_rst_in_ready", 128'(bus.in_ready), 128'(0));
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        send(V1, 1'b0, E1, LAT);

        // Round trip through the encrypt MixColumns
        for (int i = 0; i < 1000; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            send(fwd_mix(d), 1'b0, d, LAT);
        end

        wait_idle();
        chk("sb_drained", 128'(sb.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
